uart_rx_os: RTL and testbench
=============================

# uart_rx_os

Parametrised, oversampling UART receiver for the ECG filter's serial input path, replacing the fixed 8N1 receiver. It synchronises the `rx` line and samples each bit with a 3-tap majority vote at mid-bit. It supports 5–9 data bits, optional odd/even parity, and 1 or 2 stop bits, and reports parity, framing and overrun errors. Received words are buffered in a small FIFO and handed to the downstream filter front-end over a valid/ready handshake.

## Interface
- `CLK_FREQ`, 50000000: system clock frequency, Hz.
- `BAUD_RATE`, 115200: line rate, baud.
- `OVERSAMPLE`, 16: sample ticks per bit; legal values are 8 or 16.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, ≥2.
- `Clk` input 1: system clock, rising edge. Clock `Clk`.
- `nRst` input 1: reset `nRst`, asynchronous, active-low.
- `rx` input 1: asynchronous serial line, idle high.
- `rx_data` output DATA_BITS: data word at the FIFO head, LSB = first bit received.
- `rx_valid` output 1: FIFO not empty.
- `rx_ready` input 1: consumer accepts the head word when `rx_valid` and `rx_ready` are both high.
- `parity_err` output 1: parity error flag of the head entry; always 0 when PARITY=0.
- `frame_err` output 1: framing error flag of the head entry (a stop bit sampled low).
- `overrun` output 1: sticky flag; a completed frame was dropped because the FIFO was full.
- `fifo_count` output $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Input synchroniser:** 2-flop synchroniser on `rx`, both flops reset to 1. All logic below uses the synchronised signal `rxs`.
- **Tick generator:** DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), using integer truncation. A free-running counter issues a one-clock `tick` every DIV clocks. Elaboration-time assertion: DIV ≥ 2.
- **Sample counter:** `scnt` counts ticks 0..OVERSAMPLE-1 within a bit.
- **Bit sampling:** each bit's value is the majority of `rxs` at ticks M-1, M and M+1, where M = OVERSAMPLE/2. The value is evaluated at tick M+1.
- **FSM states:** IDLE, START, DATA, PAR, STOP, WAIT_HI.
- **IDLE:** when `rxs`=0, go to START, clear `scnt`, and realign the tick counter so the next tick occurs DIV clocks later.
- **START:** at tick M+1, if the vote is 1 (glitch), return to IDLE. Otherwise continue counting; at `scnt` wrap, go to DATA.
- **DATA:** shifts in DATA_BITS votes, LSB first. After the last bit, go to PAR if PARITY≠0, otherwise to STOP.
- **PAR:** computes `perr`. For even parity, `perr` = XOR of (data bits, parity bit). For odd parity, `perr` = XNOR of (data bits, parity bit).
- **STOP:** samples STOP_BITS stop bits. `ferr` is set if any stop bit votes 0. The push happens at tick M+1 of the last stop bit, not at the end of the bit. After the push, go to IDLE if `ferr`=0, or to WAIT_HI if `ferr`=1.
- **WAIT_HI:** return to IDLE only once `rxs`=1. This prevents a break condition from retriggering.
- **FIFO entry:** {`perr`, `ferr`, data}. A frame with errors is still pushed; the flags travel with the data.
- **FIFO full:**
  - Push while full with no pop in the same cycle: the frame is dropped, the FIFO is unchanged, and `overrun` is set to 1.
  - Push while full with a pop in the same cycle: both occur, no overrun, and `fifo_count` is unchanged.
- **Clearing `overrun`:** cleared on the first pop after it was set. If a drop and a pop coincide, set wins.

## Timing
- **Reset values:** `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `fifo_count`=0. FSM in IDLE, all counters 0.
- **Reset mid-frame:** the partial frame is discarded. After release, the FSM waits in IDLE.
- **Synchroniser latency:** 2 clocks from `rx` to `rxs`.
- **Push latency:** `rx_valid` rises, and the head outputs update, on the clock after the push cycle.
- **Outputs are registered-from-FIFO:** `rx_data`, `parity_err` and `frame_err` are stable while `rx_valid`=1 and no pop occurs.
- **Pop:** on a pop, the next entry, or `rx_valid`=0, appears on the following clock. Back-to-back pops at one per clock are supported.
- **Start detection:** a start-bit low shorter than about M+2 ticks is rejected as a glitch with no push.

## Structure
- **Package `uart_pkg`:**
  - `parity_e` (NONE, ODD, EVEN).
  - `rx_state_e` (the six FSM states).
  - Function `majority3`.
- **Sub-module `sync_fifo`:** parameters WIDTH and DEPTH; ports `push`, `pop`, `din`, `dout`, `count`, `full`, `empty`. Show-ahead output. It is reused by the TX path later.
- **Kept in `uart_rx_os`:** synchroniser, tick generator, FSM and overrun flag.

## Test plan
All scenarios use defaults unless stated (DIV=27, 432 clocks per bit).
- **Basic 8N1 receive:** send 0xA5 with `rx_ready`=1 → one `rx_valid` pulse with `rx_data`=0xA5, `parity_err`=0, `frame_err`=0.
- **Parity:**
  - PARITY=2, DATA_BITS=7: send 0x41 with correct parity bit 0 → `parity_err`=0.
  - Same setup, parity bit forced to 1 → data 0x41 with `parity_err`=1.
- **Stop bits and break:**
  - STOP_BITS=2, second stop bit driven low → `frame_err`=1.
  - Hold `rx` low for 20 bits → exactly one entry (0x00, `frame_err`=1) and no further frames until `rx` returns high.
- **Glitch rejection:** a 3-tick (81-clock) low pulse on an idle line → no push, FSM back in IDLE, `rx_valid` stays 0.
- **Overrun:** `rx_ready`=0, send 5 frames 0x01..0x05 → `fifo_count`=4, `overrun`=1, and pops return 0x01..0x04. `overrun` clears on the first pop.
- **Async reset mid-frame:** assert `nRst` in the middle of the DATA state → all outputs return to 0 immediately. A following frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the oversampling UART receive path
package uart_pkg;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      ODD  = 2'd1,
      EVEN = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP,
      WAIT_HI
   } rx_state_e;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO; a push into a full FIFO only lands
// when a pop frees the slot in the same cycle
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                    Clk,
   input  logic                    nRst,
   input  logic                    push,
   input  logic                    pop,
   input  logic [WIDTH-1:0]        din,
   output logic [WIDTH-1:0]        dout,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_COUNT);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop) count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with majority-vote sampling,
// parity/framing/overrun reporting and a show-ahead output FIFO
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          Clk,
   input  logic                          nRst,
   input  logic                          rx,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic                          parity_err,
   output logic                          frame_err,
   output logic                          overrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int M   = OVERSAMPLE / 2;
   localparam int DW  = $clog2(DIV);
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(DATA_BITS + 1);
   localparam parity_e PMODE = parity_e'(PARITY[1:0]);

   if (DIV < 2) begin : g_div_check
      $error("uart_rx_os: clock divider DIV must be at least 2");
   end

   logic [1:0]           sync;
   logic                 rxs;
   logic [DW-1:0]        div_cnt;
   logic                 tick;
   logic [SW-1:0]        scnt;
   logic [1:0]           early;
   logic                 vote;
   logic                 at_vote;
   logic                 at_wrap;
   rx_state_e            state;
   rx_state_e            state_nxt;
   logic [DATA_BITS-1:0] shreg;
   logic [BW-1:0]        bit_cnt;
   logic                 stop_cnt;
   logic                 perr;
   logic                 ferr;
   logic                 ferr_now;
   logic                 start_det;
   logic                 push;
   logic                 pop;
   logic                 full;
   logic                 empty;

   assign rxs     = sync[1];
   assign tick    = (div_cnt == DW'(DIV - 1));
   assign at_vote = tick && (scnt == SW'(M + 1));
   assign at_wrap = tick && (scnt == SW'(OVERSAMPLE - 1));
   // early[] holds the M-1 and M samples; the third vote is the live sample at M+1
   assign vote    = majority3(early[1], early[0], rxs);

   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_det = 1'b0;
      push      = 1'b0;
      ferr_now  = ferr | ~vote;
      case (state)
         IDLE: begin
            if (!rxs) begin
               state_nxt = START;
               start_det = 1'b1;
            end
         end
         START: begin
            if (at_vote && vote)  state_nxt = IDLE;
            else if (at_wrap)     state_nxt = DATA;
         end
         DATA: begin
            if (at_wrap && bit_cnt == BW'(DATA_BITS))
               state_nxt = (PMODE == NONE) ? STOP : PAR;
         end
         PAR: begin
            if (at_wrap) state_nxt = STOP;
         end
         STOP: begin
            if (at_vote && stop_cnt == 1'(STOP_BITS - 1)) begin
               push      = 1'b1;
               state_nxt = ferr_now ? WAIT_HI : IDLE;
            end
         end
         WAIT_HI: begin
            if (rxs) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         sync     <= 2'b11;
         div_cnt  <= '0;
         scnt     <= '0;
         early    <= '0;
         shreg    <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         perr     <= 1'b0;
         ferr     <= 1'b0;
      end else begin
         sync <= {sync[0], rx};
         // restarting the divider on start detection centres the ticks on the frame
         if (start_det || tick) div_cnt <= '0;
         else                   div_cnt <= div_cnt + 1'b1;
         if (start_det) begin
            scnt     <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
         end else if (tick) begin
            scnt <= scnt + 1'b1;
            if (scnt == SW'(M - 1)) early[1] <= rxs;
            if (scnt == SW'(M))     early[0] <= rxs;
            if (scnt == SW'(M + 1)) begin
               case (state)
                  DATA: begin
                     shreg   <= {vote, shreg[DATA_BITS-1:1]};
                     bit_cnt <= bit_cnt + 1'b1;
                  end
                  PAR:     perr <= (^shreg) ^ vote ^ (PMODE == ODD);
                  STOP:    ferr <= ferr_now;
                  default: ;
               endcase
            end
            if (at_wrap && state == STOP) stop_cnt <= stop_cnt + 1'b1;
         end
      end
   end

   assign pop      = rx_valid & rx_ready;
   assign rx_valid = ~empty;

   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst)                   overrun <= 1'b0;
      else if (push && full && !pop) overrun <= 1'b1;
      else if (pop)                overrun <= 1'b0;
   end

   sync_fifo #(
      .WIDTH (DATA_BITS + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .Clk   (Clk),
      .nRst  (nRst),
      .push  (push),
      .pop   (pop),
      .din   ({perr, ferr_now, shreg}),
      .dout  ({parity_err, frame_err, rx_data}),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - scoreboard bench: an 8N1 instance and a 7E2 instance driven
// with random frames, checked against a frame-level reference model
module tb_uart_rx_os;
   localparam int CLK_FREQ = 50000000;
   localparam int BAUD     = 115200;
   localparam int OS       = 16;
   localparam int DEPTH    = 4;
   localparam int BIT_CLKS = (CLK_FREQ / (BAUD * OS)) * OS;

   typedef struct packed {
      logic [8:0] data;
      logic       perr;
      logic       ferr;
   } entry_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       nrst_a, nrst_b, rx_a, rx_b, ready_a, ready_b;
   logic [7:0] data_a;
   logic [6:0] data_b;
   logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b, ovr_a, ovr_b;
   logic [2:0] cnt_a, cnt_b;
   logic       exp_ovr_a;
   int         checks = 0;
   int         failures = 0;
   entry_t     q_a[$];
   entry_t     q_b[$];

   uart_rx_os #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_a (
      .Clk(clk), .nRst(nrst_a), .rx(rx_a), .rx_data(data_a), .rx_valid(valid_a),
      .rx_ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a),
      .fifo_count(cnt_a));

   uart_rx_os #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_b (
      .Clk(clk), .nRst(nrst_b), .rx(rx_b), .rx_data(data_b), .rx_valid(valid_b),
      .rx_ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b),
      .fifo_count(cnt_b));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected FIFO entry for a frame, from the bits placed on the line
   function automatic entry_t model(input logic [8:0] data, input int nbits, input int pmode,
                                    input logic pbit, input int nstop, input logic [1:0] stops);
      entry_t e;
      int     ones = 0;
      e.data = '0;
      for (int i = 0; i < nbits; i++) begin
         e.data[i] = data[i];
         ones += int'(data[i]);
      end
      ones += int'(pbit);
      e.perr = (pmode == 2) ? (ones % 2 != 0) : (pmode == 1) ? (ones % 2 == 0) : 1'b0;
      e.ferr = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
      return e;
   endfunction

   task automatic drive_bit(input int which, input logic b, input int clks);
      @(negedge clk);
      if (which == 0) rx_a = b;
      else            rx_b = b;
      repeat (clks - 1) @(negedge clk);
   endtask

   task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                             input int pmode, input logic pbit, input int nstop,
                             input logic [1:0] stops);
      drive_bit(which, 1'b0, BIT_CLKS);
      for (int i = 0; i < nbits; i++) drive_bit(which, data[i], BIT_CLKS);
      if (pmode != 0) drive_bit(which, pbit, BIT_CLKS);
      for (int i = 0; i < nstop; i++) drive_bit(which, stops[i], BIT_CLKS);
      drive_bit(which, 1'b1, BIT_CLKS);
   endtask

   // With rx_ready low the scoreboard queue is the FIFO content, so a full queue means a drop
   task automatic xfer_a(input logic [8:0] data, input logic stop);
      entry_t e;
      e = model(data, 8, 0, 1'b0, 1, {1'b1, stop});
      if (!ready_a && q_a.size() >= DEPTH) exp_ovr_a = 1'b1;
      else                                 q_a.push_back(e);
      send_frame(0, data, 8, 0, 1'b0, 1, {1'b1, stop});
   endtask

   task automatic xfer_b(input logic [8:0] data, input logic pbit, input logic [1:0] stops);
      q_b.push_back(model(data, 7, 2, pbit, 2, stops));
      send_frame(1, data, 7, 2, pbit, 2, stops);
   endtask

   initial forever begin : mon_a
      entry_t e;
      @(negedge clk);
      #1;
      if (valid_a && ready_a) begin
         if (q_a.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_unexpected_word: got 0x%0h, expected no word", data_a);
         end else begin
            e = q_a.pop_front();
            check("a_data", 32'(data_a), 32'(e.data));
            check("a_parity_err", 32'(perr_a), 32'(e.perr));
            check("a_frame_err", 32'(ferr_a), 32'(e.ferr));
         end
      end
   end

   initial forever begin : mon_b
      entry_t e;
      @(negedge clk);
      #1;
      if (valid_b && ready_b) begin
         if (q_b.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_unexpected_word: got 0x%0h, expected no word", data_b);
         end else begin
            e = q_b.pop_front();
            check("b_data", 32'(data_b), 32'(e.data));
            check("b_parity_err", 32'(perr_b), 32'(e.perr));
            check("b_frame_err", 32'(ferr_b), 32'(e.ferr));
         end
      end
   end

   task automatic run_a();
      xfer_a(9'h0A5, 1'b1);
      // 81-clock low pulse must be rejected as a glitch
      drive_bit(0, 1'b0, 81);
      drive_bit(0, 1'b1, 2 * BIT_CLKS);
      check("glitch_valid", 32'(valid_a), 0);
      check("glitch_count", 32'(cnt_a), 0);
      for (int i = 0; i < 3; i++)
         xfer_a(9'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0));
      // break: line low for 20 bit times yields one errored all-zero word
      q_a.push_back(model(9'h000, 8, 0, 1'b0, 1, 2'b00));
      drive_bit(0, 1'b0, 20 * BIT_CLKS);
      check("break_count", 32'(cnt_a), 0);
      drive_bit(0, 1'b1, 2 * BIT_CLKS);
      check("break_valid", 32'(valid_a), 0);
      // overrun: five frames into a four-entry FIFO with the consumer stalled
      @(negedge clk);
      ready_a = 1'b0;
      for (int i = 1; i <= 5; i++) xfer_a(9'(i), 1'b1);
      check("ovr_count", 32'(cnt_a), DEPTH);
      check("ovr_flag", 32'(ovr_a), 32'(exp_ovr_a));
      check("ovr_head", 32'(data_a), 1);
      @(negedge clk);
      ready_a = 1'b1;
      @(negedge clk);
      #2;
      exp_ovr_a = 1'b0;
      check("ovr_cleared", 32'(ovr_a), 32'(exp_ovr_a));
      check("ovr_count_after_pop", 32'(cnt_a), DEPTH - 1);
      repeat (8) @(negedge clk);
      check("ovr_drained", 32'(cnt_a), 0);
      // reset in the middle of a frame, with a word waiting in the FIFO
      ready_a = 1'b0;
      send_frame(0, 9'h05A, 8, 0, 1'b0, 1, 2'b01);
      check("pre_reset_valid", 32'(valid_a), 1);
      check("pre_reset_data", 32'(data_a), 32'h5A);
      drive_bit(0, 1'b0, BIT_CLKS);
      drive_bit(0, 1'b1, BIT_CLKS);
      drive_bit(0, 1'b0, BIT_CLKS);
      drive_bit(0, 1'b1, BIT_CLKS / 2);
      #1;
      nrst_a = 1'b0;
      #1;
      check("reset_valid", 32'(valid_a), 0);
      check("reset_data", 32'(data_a), 0);
      check("reset_count", 32'(cnt_a), 0);
      check("reset_ferr", 32'(ferr_a), 0);
      rx_a = 1'b1;
      repeat (5) @(negedge clk);
      nrst_a = 1'b1;
      drive_bit(0, 1'b1, BIT_CLKS);
      ready_a = 1'b1;
      xfer_a(9'h03C, 1'b1);
   endtask

   task automatic run_b();
      logic [8:0] d;
      xfer_b(9'h041, 1'b0, 2'b11);
      xfer_b(9'h041, 1'b1, 2'b11);
      d = 9'($urandom_range(0, 127));
      xfer_b(d, ^d, 2'b01);
      for (int i = 0; i < 3; i++) begin
         d = 9'($urandom_range(0, 127));
         xfer_b(d, 1'($urandom_range(0, 1)),
                {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)});
      end
   endtask

   initial begin : watchdog
      repeat (99000) @(posedge clk);
      $display("FAIL watchdog: run still active after 99000 clocks, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      nrst_a    = 1'b0;
      nrst_b    = 1'b0;
      rx_a      = 1'b1;
      rx_b      = 1'b1;
      ready_a   = 1'b1;
      ready_b   = 1'b1;
      exp_ovr_a = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_valid", 32'(valid_a), 0);
      check("rst_data", 32'(data_a), 0);
      check("rst_parity_err", 32'(perr_a), 0);
      check("rst_frame_err", 32'(ferr_a), 0);
      check("rst_overrun", 32'(ovr_a), 0);
      check("rst_count", 32'(cnt_a), 0);
      check("rst_b_valid", 32'(valid_b), 0);
      check("rst_b_count", 32'(cnt_b), 0);
      @(negedge clk);
      nrst_a = 1'b1;
      nrst_b = 1'b1;
      repeat (4) @(negedge clk);
      fork
         run_a();
         run_b();
      join
      repeat (20) @(negedge clk);
      check("a_queue_drained", 32'(q_a.size()), 0);
      check("b_queue_drained", 32'(q_b.size()), 0);
      check("b_overrun", 32'(ovr_b), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
